alu4_sequencer: RTL and testbench
=================================

Name: alu4_sequencer

Overview:
- Control and writeback stage wrapped around the 4-bit ALU datapath.
- Accepts register-level commands over a valid/ready handshake and reads operands from a small register file.
- Drives the ALU opcode, operands and both carry-ins (math and rotate) from its own flags register.
- Samples the ALU result and flags, writes them back, and returns the result on a valid/ready response port.

Parameters:
- NREGS, 4, number of 4-bit registers (power of two, 2..8); AW = log2(NREGS) is derived.
- ALU_WAIT, 1, cycles operands are held on the ALU before the result is sampled (1..7).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid & ready
- cmd_op  in  4  ALU opcode, passed through unmodified
- cmd_rd, cmd_rs1, cmd_rs2  in  AW each  destination / operand-A / operand-B register
- cmd_wb  in  1  write result to rd
- cmd_fl  in  1  update flags
- cmd_ld  in  1  immediate load: bypass ALU
- cmd_imm  in  4  immediate value
- alu_a, alu_b  out  4  operands to ALU
- alu_op  out  4  opcode to ALU
- alu_cin  out  1  math carry-in (= C flag)
- alu_rcin  out  1  rotate carry-in (= R flag)
- alu_out  in  4  ALU result
- alu_co, alu_rco, alu_ov, alu_z  in  1 each  ALU math carry, rotate carry, overflow, zero
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_data  out  4  result (or immediate)
- rsp_flags  out  4  {Z,V,R,C} after this command
- flags  out  4  architectural {Z,V,R,C}

Behaviour:
- One clock, clk; reset rst is synchronous, active-high.
- Reset state: state=IDLE, all registers 0, flags 0, rsp_valid 0, rsp_data 0, rsp_flags 0, alu_a/alu_b/alu_op 0. cmd_ready is 1 from the first cycle after reset.
- Reset asserted in any state overrides everything: the in-flight command is dropped, no writeback occurs, rsp_valid drops on the next edge.
- States:
  - IDLE: cmd_ready=1. On accept:
    - Latch op, rd, wb, fl.
    - Latch operands reg[rs1]→alu_a, reg[rs2]→alu_b, op→alu_op (registered outputs).
    - Load wait counter with ALU_WAIT-1.
    - Go to ISSUE, or to RESP if cmd_ld=1.
  - ISSUE: cmd_ready=0; operands stable. Counter decrements each cycle. At the edge where counter==0:
    - Sample alu_out and flags.
    - If wb, reg[rd] <= alu_out.
    - If fl, flags <= {alu_z, alu_ov, alu_rco, alu_co}.
    - rsp_data <= alu_out; rsp_flags <= post-update flags; go to RESP.
  - RESP: rsp_valid=1; rsp_data and rsp_flags held stable. On rsp_ready, go to IDLE.
- Immediate load: at accept, if wb, reg[rd] <= cmd_imm. Flags are unchanged regardless of fl. rsp_data <= cmd_imm; go to RESP.
- alu_cin/alu_rcin: combinational from the flags register. Stable through ISSUE because flags only change at the sampling edge.
- Latency:
  - ALU command: accept edge → rsp_valid after ALU_WAIT+1 edges.
  - Immediate: 1 edge.
  - Minimum command period: ALU_WAIT+2 cycles with rsp_ready tied high.
- Hazards:
  - Operands are latched at accept, so rd==rs1/rs2 reads old values.
  - The next command sees the written value (no forwarding needed because issue is serialised).
- Flag dependency: alu_cin for command N+1 reflects flags written by command N.
- Backpressure: rsp_ready low holds RESP indefinitely; cmd_ready stays 0; no state changes.
- Inputs are ignored when not in the stated states: cmd_* outside IDLE; rsp_ready outside RESP. alu_* inputs are ignored except at the sampling edge.
- No register is hardwired to zero.
- Register index ≥ NREGS is impossible by width.

Decomposition:
- Shared package:
  - State enum {IDLE, ISSUE, RESP}.
  - Flag bit positions FLG_C=0, FLG_R=1, FLG_V=2, FLG_Z=3.
  - Reset constants.
- One sub-module: alu4_regfile (NREGS×4, two combinational read ports, one synchronous write port, sync reset to 0).
- The FSM, counter and handshakes stay in the top.

Test Plan:
- Reset, then immediate loads r1=4'h9 and r2=4'h7 → each response one edge after accept, rsp_data=9 then 7, flags=0.
- ALU command rs1=1, rs2=2, rd=3, wb=1, fl=1, with a bench ALU stub returning alu_out=0, co=1, z=1 →
  - alu_a=9, alu_b=7 throughout ISSUE;
  - rsp_valid at accept+2 edges (ALU_WAIT=1);
  - rsp_flags=4'b1001;
  - r3=0.
- Follow-up command → alu_cin=1 during its ISSUE; with fl=0 the flags stay 4'b1001 even though the stub returns co=0.
- Hold rsp_ready=0 for 5 cycles → rsp_valid, rsp_data and rsp_flags are stable; cmd_ready=0; a cmd_valid pulse is not accepted.
- rd==rs1 (rd=1, rs1=1, r1=9) → alu_a=9 captured; after wb, r1 holds the stub result.
- rst asserted mid-ISSUE with wb=1 → target register stays 0; rsp_valid=0 next edge; cmd_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/alu4_sequencer_pkg.sv
// Shared types and constants for the 4-bit ALU control/writeback stage.
// Flag vectors are always packed as {Z,V,R,C}.
package alu4_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam int FLG_C = 0;
    localparam int FLG_R = 1;
    localparam int FLG_V = 2;
    localparam int FLG_Z = 3;

    // Wait counter is wide enough for the largest supported ALU_WAIT of 7.
    localparam int CNT_W = 3;

    localparam logic [3:0] RST_NIBBLE = 4'h0;
    localparam logic [3:0] RST_FLAGS  = 4'h0;

    function automatic logic [3:0] pack_flags(input logic z, input logic v,
                                              input logic r, input logic c);
        logic [3:0] f;
        f        = RST_FLAGS;
        f[FLG_Z] = z;
        f[FLG_V] = v;
        f[FLG_R] = r;
        f[FLG_C] = c;
        return f;
    endfunction

endpackage

// File: rtl/alu4_regfile.sv
// NREGS x 4-bit register file: two combinational read ports, one
// synchronous write port, synchronous reset to zero.
module alu4_regfile
    import alu4_sequencer_pkg::*;
#(
    parameter int NREGS = 4,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra_addr,
    output logic [3:0]    ra_data,
    input  logic [AW-1:0] rb_addr,
    output logic [3:0]    rb_data,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [3:0]    wd
);

    logic [3:0] regs_q [NREGS];
    logic [3:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[wa] = wd;
        end
    end

    // Reset has priority, so a write requested on the reset edge is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= RST_NIBBLE;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign ra_data = regs_q[ra_addr];
    assign rb_data = regs_q[rb_addr];

endmodule

// File: rtl/alu4_sequencer.sv
// Control and writeback stage around the 4-bit ALU: accepts register
// commands, issues operands to the ALU, writes back and responds.
module alu4_sequencer
    import alu4_sequencer_pkg::*;
#(
    parameter int  NREGS    = 4,
    parameter int  ALU_WAIT = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rs1,
    input  logic [AW-1:0] cmd_rs2,
    input  logic          cmd_wb,
    input  logic          cmd_fl,
    input  logic          cmd_ld,
    input  logic [3:0]    cmd_imm,
    output logic [3:0]    alu_a,
    output logic [3:0]    alu_b,
    output logic [3:0]    alu_op,
    output logic          alu_cin,
    output logic          alu_rcin,
    input  logic [3:0]    alu_out,
    input  logic          alu_co,
    input  logic          alu_rco,
    input  logic          alu_ov,
    input  logic          alu_z,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [3:0]    rsp_data,
    output logic [3:0]    rsp_flags,
    output logic [3:0]    flags
);

    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(ALU_WAIT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       alu_a_q, alu_a_d;
    logic [3:0]       alu_b_q, alu_b_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic             wb_q, wb_d;
    logic             fl_q, fl_d;
    logic [3:0]       flags_q, flags_d;
    logic [3:0]       rsp_data_q, rsp_data_d;
    logic [3:0]       rsp_flags_q, rsp_flags_d;

    logic             accept;
    logic             sample;
    logic [3:0]       rs1_data, rs2_data;
    logic [3:0]       alu_flags;
    logic             rf_we;
    logic [AW-1:0]    rf_waddr;
    logic [3:0]       rf_wdata;

    alu4_regfile #(
        .NREGS(NREGS),
        .AW   (AW)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .ra_addr(cmd_rs1),
        .ra_data(rs1_data),
        .rb_addr(cmd_rs2),
        .rb_data(rs2_data),
        .we     (rf_we),
        .wa     (rf_waddr),
        .wd     (rf_wdata)
    );

    assign alu_flags = pack_flags(alu_z, alu_ov, alu_rco, alu_co);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid) state_d = cmd_ld ? RESP : ISSUE;
            ISSUE:   if (cnt_q == '0) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Both ports transfer on a cycle where valid and ready are high together;
    // ready never depends on valid, and valid/data hold until the transfer.
    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE:    cmd_ready = 1'b1;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
        accept = cmd_ready & cmd_valid;
        sample = (state_q == ISSUE) && (cnt_q == '0);
    end

    always_comb begin
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rd_d        = rd_q;
        wb_d        = wb_q;
        fl_d        = fl_q;
        cnt_d       = cnt_q;
        flags_d     = flags_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        rf_we       = 1'b0;
        rf_waddr    = cmd_rd;
        rf_wdata    = cmd_imm;

        if (accept) begin
            alu_a_d  = rs1_data;
            alu_b_d  = rs2_data;
            alu_op_d = cmd_op;
            rd_d     = cmd_rd;
            wb_d     = cmd_wb;
            fl_d     = cmd_fl;
            cnt_d    = WAIT_INIT;
            // Immediate loads bypass the ALU and never touch the flags.
            if (cmd_ld) begin
                rf_we       = cmd_wb;
                rsp_data_d  = cmd_imm;
                rsp_flags_d = flags_q;
            end
        end else if (state_q == ISSUE) begin
            cnt_d = cnt_q - 1'b1;
            if (sample) begin
                rf_we       = wb_q;
                rf_waddr    = rd_q;
                rf_wdata    = alu_out;
                flags_d     = fl_q ? alu_flags : flags_q;
                rsp_data_d  = alu_out;
                rsp_flags_d = fl_q ? alu_flags : flags_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_q     <= RST_NIBBLE;
            alu_b_q     <= RST_NIBBLE;
            alu_op_q    <= RST_NIBBLE;
            rd_q        <= '0;
            wb_q        <= 1'b0;
            fl_q        <= 1'b0;
            cnt_q       <= '0;
            flags_q     <= RST_FLAGS;
            rsp_data_q  <= RST_NIBBLE;
            rsp_flags_q <= RST_FLAGS;
        end else begin
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rd_q        <= rd_d;
            wb_q        <= wb_d;
            fl_q        <= fl_d;
            cnt_q       <= cnt_d;
            flags_q     <= flags_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign alu_cin   = flags_q[FLG_C];
    assign alu_rcin  = flags_q[FLG_R];
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu4_sequencer.sv
// Self-checking bench for alu4_sequencer: directed vector table with a
// fixed-value ALU stub, reset corner case, then random commands vs a model.
module tb_alu4_sequencer;

    localparam int NREGS    = 4;
    localparam int ALU_WAIT = 1;
    localparam int AW       = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready;
    logic [3:0]    cmd_op, cmd_imm;
    logic [AW-1:0] cmd_rd, cmd_rs1, cmd_rs2;
    logic          cmd_wb, cmd_fl, cmd_ld;
    logic [3:0]    alu_a, alu_b, alu_op;
    logic          alu_cin, alu_rcin;
    logic [3:0]    alu_out;
    logic          alu_co, alu_rco, alu_ov, alu_z;
    logic          rsp_valid, rsp_ready;
    logic [3:0]    rsp_data, rsp_flags, flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu4_sequencer #(.NREGS(NREGS), .ALU_WAIT(ALU_WAIT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_wb(cmd_wb), .cmd_fl(cmd_fl), .cmd_ld(cmd_ld), .cmd_imm(cmd_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_cin(alu_cin), .alu_rcin(alu_rcin),
        .alu_out(alu_out), .alu_co(alu_co), .alu_rco(alu_rco),
        .alu_ov(alu_ov), .alu_z(alu_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags), .flags(flags)
    );

    // ALU stub: fixed values for directed vectors, or a simple arithmetic
    // function of the operands and carry-ins for random testing.
    logic       stub_fn;
    logic [3:0] s_out;
    logic       s_co, s_rco, s_ov, s_z;
    logic [4:0] sum5;

    always_comb begin
        sum5 = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
        if (stub_fn) begin
            alu_out = sum5[3:0] ^ alu_op;
            alu_co  = sum5[4];
            alu_rco = alu_rcin ^ alu_op[0];
            alu_ov  = alu_a[3] ^ alu_b[3];
            alu_z   = ((sum5[3:0] ^ alu_op) == 4'h0);
        end else begin
            alu_out = s_out;
            alu_co  = s_co;
            alu_rco = s_rco;
            alu_ov  = s_ov;
            alu_z   = s_z;
        end
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Drives one command, measures accept-to-response latency, optionally
    // holds the response under backpressure, then consumes it.
    task automatic run_cmd(input logic ld, input logic wb, input logic fl,
                           input logic [3:0] op, input logic [3:0] imm,
                           input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                           input logic [AW-1:0] rs2, input int hold,
                           output logic [3:0] d, output logic [3:0] f,
                           output logic [3:0] a, output logic [3:0] b,
                           output logic [3:0] aop, output logic cin,
                           output logic rcin, output int lat);
        int guard;
        @(negedge clk);
        cmd_ld = ld; cmd_wb = wb; cmd_fl = fl; cmd_op = op; cmd_imm = imm;
        cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_valid = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk1("cmd_ready_wait", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op = ~op; cmd_imm = ~imm; cmd_rs1 = ~rs1; cmd_rs2 = ~rs2; cmd_rd = ~rd;
        a = alu_a; b = alu_b; aop = alu_op; cin = alu_cin; rcin = alu_rcin;
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        d = rsp_data;
        f = rsp_flags;
        for (int h = 0; h < hold; h++) begin
            if (h == 1) begin
                cmd_valid = 1'b1; cmd_ld = 1'b1; cmd_wb = 1'b1;
                cmd_rd = '0; cmd_imm = 4'h5;
            end
            if (h == 2) cmd_valid = 1'b0;
            @(posedge clk); #1;
            chk1("hold_rsp_valid", rsp_valid, 1'b1);
            chk4("hold_rsp_data", rsp_data, d);
            chk4("hold_rsp_flags", rsp_flags, f);
            chk1("hold_cmd_ready", cmd_ready, 1'b0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk1("rsp_drop", rsp_valid, 1'b0);
    endtask

    typedef struct {
        logic ld, wb, fl;
        logic [3:0] op, imm;
        logic [AW-1:0] rd, rs1, rs2;
        int hold;
        logic [3:0] s_out;
        logic s_co, s_rco, s_ov, s_z;
        logic [3:0] exp_a, exp_b;
        logic exp_cin, exp_rcin;
        logic [3:0] exp_data, exp_flags;
        int exp_lat;
    } vec_t;

    vec_t vecs[9];

    logic [3:0]    got_d, got_f, got_a, got_b, got_op;
    logic          got_cin, got_rcin;
    int            got_lat;
    logic [3:0]    m_reg [NREGS];
    logic [3:0]    m_flags;
    logic          r_ld, r_wb, r_fl;
    logic [3:0]    r_op, r_imm, e_a, e_b, e_data;
    logic [AW-1:0] r_rd, r_rs1, r_rs2;
    logic          e_cin, e_co, e_rco, e_ov, e_z;
    int            e_sum;

    initial begin
        //           ld    wb    fl    op    imm   rd    rs1   rs2  hold s_out co    rco   ov    z     exp_a exp_b cin   rcin  data  flags lat
        vecs[0] = '{1'b1, 1'b1, 1'b0, 4'h0, 4'h9, 2'd1, 2'd0, 2'd0, 0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h9, 4'h0, 1};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 4'h0, 4'h7, 2'd2, 2'd0, 2'd0, 0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h7, 4'h0, 1};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 4'h2, 4'h0, 2'd3, 2'd1, 2'd2, 0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h9, 4'h7, 1'b0, 1'b0, 4'h0, 4'h9, 2};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 4'h4, 4'h0, 2'd0, 2'd3, 2'd1, 5, 4'h5, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h9, 1'b1, 1'b0, 4'h5, 4'h9, 2};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 4'h0, 4'hC, 2'd0, 2'd0, 2'd0, 0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 4'hC, 4'h9, 1};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 4'h3, 4'h0, 2'd1, 2'd1, 2'd0, 0, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 4'h9, 4'hC, 1'b1, 1'b0, 4'h6, 4'h9, 2};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 4'h5, 4'h0, 2'd2, 2'd1, 2'd2, 0, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 4'h6, 4'h7, 1'b1, 1'b0, 4'h3, 4'h6, 2};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 2'd2, 2'd0, 2'd0, 0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'hF, 4'h6, 1};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 4'hA, 4'h0, 2'd0, 2'd2, 2'd2, 0, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0, 4'h7, 4'h7, 1'b0, 1'b1, 4'hA, 4'h1, 2};

        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = '0; cmd_imm = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0;
        cmd_wb = 1'b0; cmd_fl = 1'b0; cmd_ld = 1'b0;
        stub_fn = 1'b0; s_out = '0; s_co = 1'b0; s_rco = 1'b0; s_ov = 1'b0; s_z = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk1("reset_rsp_valid", rsp_valid, 1'b0);
        chk4("reset_rsp_data", rsp_data, 4'h0);
        chk4("reset_rsp_flags", rsp_flags, 4'h0);
        chk4("reset_alu_a", alu_a, 4'h0);
        chk4("reset_alu_b", alu_b, 4'h0);
        chk4("reset_alu_op", alu_op, 4'h0);
        chk4("reset_flags", flags, 4'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk1("reset_cmd_ready", cmd_ready, 1'b1);

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            s_out = vecs[i].s_out; s_co = vecs[i].s_co; s_rco = vecs[i].s_rco;
            s_ov = vecs[i].s_ov; s_z = vecs[i].s_z;
            run_cmd(vecs[i].ld, vecs[i].wb, vecs[i].fl, vecs[i].op, vecs[i].imm,
                    vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].hold,
                    got_d, got_f, got_a, got_b, got_op, got_cin, got_rcin, got_lat);
            chki($sformatf("vec%0d_latency", i), got_lat, vecs[i].exp_lat);
            chk4($sformatf("vec%0d_rsp_data", i), got_d, vecs[i].exp_data);
            chk4($sformatf("vec%0d_rsp_flags", i), got_f, vecs[i].exp_flags);
            chk4($sformatf("vec%0d_flags", i), flags, vecs[i].exp_flags);
            if (!vecs[i].ld) begin
                chk4($sformatf("vec%0d_alu_a", i), got_a, vecs[i].exp_a);
                chk4($sformatf("vec%0d_alu_b", i), got_b, vecs[i].exp_b);
                chk4($sformatf("vec%0d_alu_op", i), got_op, vecs[i].op);
                chk1($sformatf("vec%0d_alu_cin", i), got_cin, vecs[i].exp_cin);
                chk1($sformatf("vec%0d_alu_rcin", i), got_rcin, vecs[i].exp_rcin);
            end
        end

        // Reset asserted while the command is in ISSUE
        s_out = 4'hF; s_co = 1'b1; s_rco = 1'b1; s_ov = 1'b1; s_z = 1'b0;
        @(negedge clk);
        cmd_ld = 1'b0; cmd_wb = 1'b1; cmd_fl = 1'b1; cmd_op = 4'h1;
        cmd_rd = 2'd3; cmd_rs1 = 2'd1; cmd_rs2 = 2'd2; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk1("issue_cmd_ready", cmd_ready, 1'b0);
        chk1("issue_rsp_valid", rsp_valid, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk1("midrst_rsp_valid", rsp_valid, 1'b0);
        chk4("midrst_flags", flags, 4'h0);
        chk4("midrst_rsp_data", rsp_data, 4'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk1("midrst_cmd_ready", cmd_ready, 1'b1);
        s_out = 4'h2; s_co = 1'b0; s_rco = 1'b0; s_ov = 1'b0; s_z = 1'b0;
        run_cmd(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 2'd3, 2'd1, 0,
                got_d, got_f, got_a, got_b, got_op, got_cin, got_rcin, got_lat);
        chk4("midrst_r3", got_a, 4'h0);
        chk4("midrst_r1", got_b, 4'h0);
        chki("midrst_latency", got_lat, ALU_WAIT + 1);

        // Random commands against the reference model
        stub_fn = 1'b1;
        for (int i = 0; i < NREGS; i++) m_reg[i] = 4'h0;
        m_flags = 4'h0;
        for (int n = 0; n < 150; n++) begin
            r_ld  = ($urandom_range(0, 3) == 0);
            r_wb  = 1'($urandom_range(0, 1));
            r_fl  = 1'($urandom_range(0, 1));
            r_op  = 4'($urandom_range(0, 15));
            r_imm = 4'($urandom_range(0, 15));
            r_rd  = AW'($urandom_range(0, NREGS - 1));
            r_rs1 = AW'($urandom_range(0, NREGS - 1));
            r_rs2 = AW'($urandom_range(0, NREGS - 1));
            e_a = m_reg[r_rs1];
            e_b = m_reg[r_rs2];
            e_cin = m_flags[0];
            if (r_ld) begin
                e_data = r_imm;
                if (r_wb) m_reg[r_rd] = r_imm;
            end else begin
                e_sum  = int'(e_a) + int'(e_b) + int'(e_cin);
                e_data = 4'(e_sum) ^ r_op;
                e_co   = (e_sum > 15);
                e_rco  = m_flags[1] ^ r_op[0];
                e_ov   = e_a[3] ^ e_b[3];
                e_z    = (e_data == 4'h0);
                if (r_wb) m_reg[r_rd] = e_data;
                if (r_fl) m_flags = {e_z, e_ov, e_rco, e_co};
            end
            run_cmd(r_ld, r_wb, r_fl, r_op, r_imm, r_rd, r_rs1, r_rs2,
                    $urandom_range(0, 2),
                    got_d, got_f, got_a, got_b, got_op, got_cin, got_rcin, got_lat);
            chk4($sformatf("rnd%0d_rsp_data", n), got_d, e_data);
            chk4($sformatf("rnd%0d_rsp_flags", n), got_f, m_flags);
            chk4($sformatf("rnd%0d_flags", n), flags, m_flags);
            chki($sformatf("rnd%0d_latency", n), got_lat, r_ld ? 1 : ALU_WAIT + 1);
            if (!r_ld) begin
                chk4($sformatf("rnd%0d_alu_a", n), got_a, e_a);
                chk4($sformatf("rnd%0d_alu_b", n), got_b, e_b);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
